// File: rtl/score_keeper.sv
// Pong match control: goal scoring, frame-counted serve delay and game-over flag.
// All outputs are registered in the pclk domain.
module score_keeper #(
   parameter int unsigned WIN_SCORE    = 3,
   parameter int unsigned SERVE_FRAMES = 60
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       vsync_in,
   input  logic       goal_p1,
   input  logic       goal_p2,
   input  logic       start_in,
   output logic [1:0] score_p1,
   output logic [1:0] score_p2,
   output logic       play_en,
   output logic       serve,
   output logic       game_over
);

   localparam logic [1:0] WIN    = WIN_SCORE[1:0];
   localparam logic [7:0] FRAMES = SERVE_FRAMES[7:0];

   typedef enum logic [1:0] {IDLE, HOLD, PLAY, OVER} state_t;

   state_t     state, state_next;
   logic       vsync_q, goal1_q, goal2_q, start_q;
   logic       vsync_ev, goal1_ev, goal2_ev, start_ev;
   logic [7:0] cnt, cnt_next, cnt_inc;
   logic [1:0] p1_next, p2_next;
   logic       serve_next;

   assign vsync_ev = vsync_in & ~vsync_q;
   assign goal1_ev = goal_p1  & ~goal1_q;
   assign goal2_ev = goal_p2  & ~goal2_q;
   assign start_ev = start_in & ~start_q;
   assign cnt_inc  = cnt + 8'd1;

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      p1_next    = score_p1;
      p2_next    = score_p2;
      serve_next = 1'b0;
      case (state)
         IDLE, OVER: begin
            if (start_ev) begin
               p1_next    = '0;
               p2_next    = '0;
               cnt_next   = '0;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (vsync_ev) begin
               cnt_next = cnt_inc;
               if (cnt_inc == FRAMES) begin
                  serve_next = 1'b1;
                  state_next = PLAY;
               end
            end
         end
         PLAY: begin
            // Simultaneous goals cancel out and only force a re-serve.
            if (goal1_ev && goal2_ev) begin
               cnt_next   = '0;
               state_next = HOLD;
            end else if (goal1_ev) begin
               p1_next    = score_p1 + 2'd1;
               cnt_next   = '0;
               state_next = (p1_next == WIN) ? OVER : HOLD;
            end else if (goal2_ev) begin
               p2_next    = score_p2 + 2'd1;
               cnt_next   = '0;
               state_next = (p2_next == WIN) ? OVER : HOLD;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         vsync_q   <= 1'b0;
         goal1_q   <= 1'b0;
         goal2_q   <= 1'b0;
         start_q   <= 1'b0;
         cnt       <= '0;
         score_p1  <= '0;
         score_p2  <= '0;
         serve     <= 1'b0;
         play_en   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_next;
         vsync_q   <= vsync_in;
         goal1_q   <= goal_p1;
         goal2_q   <= goal_p2;
         start_q   <= start_in;
         cnt       <= cnt_next;
         score_p1  <= p1_next;
         score_p2  <= p2_next;
         serve     <= serve_next;
         play_en   <= (state_next == PLAY);
         game_over <= (state_next == OVER);
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: per-cycle reference model plus directed literal checks.
module tb_score_keeper;

   localparam int WIN = 3;
   localparam int SF  = 60;

   logic       pclk = 1'b0;
   logic       rst = 1'b0;
   logic       vsync_in = 1'b0, goal_p1 = 1'b0, goal_p2 = 1'b0, start_in = 1'b0;
   logic [1:0] score_p1, score_p2;
   logic       play_en, serve, game_over;

   int n_cmp = 0;
   int n_err = 0;

   score_keeper #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF)) dut (
      .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .goal_p1(goal_p1),
      .goal_p2(goal_p2), .start_in(start_in), .score_p1(score_p1),
      .score_p2(score_p2), .play_en(play_en), .serve(serve), .game_over(game_over)
   );

   always #5 pclk = ~pclk;

   task automatic cmp(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   // Reference model: match phase as text, scores and frames as plain integers.
   string phase;
   int    m_s1, m_s2, m_frames;
   bit    m_serve;
   bit    last_v, last_g1, last_g2, last_s;

   always @(posedge pclk or negedge rst) begin
      if (!rst) begin
         phase = "idle"; m_s1 = 0; m_s2 = 0; m_frames = 0; m_serve = 0;
         last_v = 0; last_g1 = 0; last_g2 = 0; last_s = 0;
      end else begin
         bit rv, r1, r2, rs;
         rv = vsync_in && !last_v;
         r1 = goal_p1 && !last_g1;
         r2 = goal_p2 && !last_g2;
         rs = start_in && !last_s;
         m_serve = 0;
         if ((phase == "idle" || phase == "over") && rs) begin
            m_s1 = 0; m_s2 = 0; m_frames = 0; phase = "hold";
         end else if (phase == "hold" && rv) begin
            m_frames++;
            if (m_frames == SF) begin
               m_serve = 1; phase = "play";
            end
         end else if (phase == "play" && (r1 || r2)) begin
            if (!(r1 && r2)) begin
               if (r1) m_s1++;
               else    m_s2++;
            end
            m_frames = 0;
            phase = (m_s1 == WIN || m_s2 == WIN) ? "over" : "hold";
         end
         last_v = vsync_in; last_g1 = goal_p1; last_g2 = goal_p2; last_s = start_in;
      end
   end

   always @(negedge pclk) begin
      cmp("m_score_p1", int'(score_p1), m_s1);
      cmp("m_score_p2", int'(score_p2), m_s2);
      cmp("m_play_en", int'(play_en), int'(phase == "play"));
      cmp("m_serve", int'(serve), int'(m_serve));
      cmp("m_game_over", int'(game_over), int'(phase == "over"));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic press_start();
      start_in = 1'b1; tick(1);
      start_in = 1'b0; tick(1);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         vsync_in = 1'b1; tick(1);
         vsync_in = 1'b0; tick(1);
      end
   endtask

   task automatic goal(input bit a, input bit b);
      goal_p1 = a; goal_p2 = b; tick(1);
      goal_p1 = 1'b0; goal_p2 = 1'b0; tick(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(3);
      rst = 1'b1;
      tick(1000);
      cmp("idle_p1", int'(score_p1), 0);
      cmp("idle_p2", int'(score_p2), 0);
      cmp("idle_play", int'(play_en), 0);
      cmp("idle_over", int'(game_over), 0);

      press_start();
      frames(59);
      cmp("no_serve_59", int'(serve), 0);
      cmp("no_play_59", int'(play_en), 0);
      vsync_in = 1'b1; tick(1);
      cmp("serve_60", int'(serve), 1);
      cmp("play_60", int'(play_en), 1);
      vsync_in = 1'b0; tick(1);
      cmp("serve_one_cycle", int'(serve), 0);

      goal_p1 = 1'b1; tick(1);
      cmp("p1_first", int'(score_p1), 1);
      cmp("p1_play_drop", int'(play_en), 0);
      tick(4);
      frames(SF);
      cmp("held_goal_p1", int'(score_p1), 1);
      cmp("held_goal_play", int'(play_en), 1);
      goal_p1 = 1'b0; tick(1);
      cmp("held_goal_p1_after", int'(score_p1), 1);

      for (int k = 1; k <= 3; k++) begin
         goal(1'b0, 1'b1);
         cmp("p2_step", int'(score_p2), k);
         if (k < 3) frames(SF);
      end
      cmp("p2_over", int'(game_over), 1);
      goal(1'b0, 1'b1);
      goal(1'b1, 1'b0);
      cmp("p2_saturate", int'(score_p2), 3);
      cmp("p1_frozen", int'(score_p1), 1);
      press_start();
      cmp("restart_p1", int'(score_p1), 0);
      cmp("restart_p2", int'(score_p2), 0);
      cmp("restart_over", int'(game_over), 0);

      frames(SF);
      goal(1'b1, 1'b1);
      cmp("tie_p1", int'(score_p1), 0);
      cmp("tie_p2", int'(score_p2), 0);
      cmp("tie_hold", int'(play_en), 0);
      frames(SF);
      cmp("tie_reserve", int'(play_en), 1);

      goal(1'b1, 1'b0); frames(SF);
      goal(1'b0, 1'b1); frames(SF);
      goal(1'b1, 1'b0); frames(10);
      cmp("pre_rst_p1", int'(score_p1), 2);
      cmp("pre_rst_p2", int'(score_p2), 1);
      @(posedge pclk); #2;
      rst = 1'b0; #1;
      cmp("async_p1", int'(score_p1), 0);
      cmp("async_p2", int'(score_p2), 0);
      cmp("async_play", int'(play_en), 0);
      cmp("async_serve", int'(serve), 0);
      cmp("async_over", int'(game_over), 0);
      tick(2);
      rst = 1'b1;
      frames(70);
      cmp("post_rst_idle", int'(play_en), 0);
      press_start();
      frames(SF);
      cmp("post_rst_play", int'(play_en), 1);
      tick(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/score_keeper.md
# score_keeper

Match-control block that produces the per-player score for the Pong game. It watches goal events from the ball logic, counts points up to a winning score, holds play for a serve delay measured in video frames, and flags game end. Its `score_p1`/`score_p2` outputs drive the result-screen overlay, which shows WIN/LOSE once either score reaches 3. It sits in the `pclk` domain between the ball/paddle logic and the draw pipeline.

## Interface
- `WIN_SCORE`, 3: points that end a match; must fit in 2 bits, range 1..3.
- `SERVE_FRAMES`, 60: frames of hold after a goal or start before a serve; range 1..255.
- `pclk`  in  1: pixel clock, the only clock.
- `rst`  in  1: reset, asynchronous, active-low (0 = reset).
- `vsync_in`  in  1: frame sync from timing chain; a rising edge counts one frame.
- `goal_p1`  in  1: ball passed player 2's edge (point for P1); level, may stay high several cycles.
- `goal_p2`  in  1: ball passed player 1's edge (point for P2).
- `start_in`  in  1: start/restart button, already debounced; a rising edge is a request.
- `score_p1`  out  2: P1 score, registered.
- `score_p2`  out  2: P2 score, registered.
- `play_en`  out  1: high while the ball may move (state PLAY).
- `serve`  out  1: one-cycle pulse that recentres and launches the ball.
- `game_over`  out  1: high in state OVER.

## Operation
- Edge detect: registered previous samples of `vsync_in`, `goal_p1`, `goal_p2` and `start_in`. An event is a current-1 / previous-0 pair. All previous-sample registers reset to 0.
- States:
  - IDLE: reset state. `start_in` edge -> clear both scores, clear the frame counter, go to HOLD.
  - HOLD: count `vsync_in` edges. When the count reaches SERVE_FRAMES: pulse `serve`, go to PLAY.
  - PLAY: goal edge events are handled as below.
  - OVER: `start_in` edge -> clear scores and counter, go to HOLD.
- Goals in PLAY:
  - `goal_p1` edge only: `score_p1` += 1.
  - `goal_p2` edge only: `score_p2` += 1.
  - Both edges in the same cycle: no score change, go to HOLD (re-serve).
  - After a scoring update: if the new score equals WIN_SCORE, go to OVER. Otherwise clear the counter and go to HOLD.
- Goal edges outside PLAY are ignored.
- `start_in` edges in HOLD or PLAY are ignored.
- Scores never exceed WIN_SCORE; no wrap from 3 to 0.
- Frame counter: 8 bits. Increments only in HOLD on a vsync edge. Cleared on every entry to HOLD.

## Timing
- Reset values: state IDLE, `score_p1`=0, `score_p2`=0, `play_en`=0, `serve`=0, `game_over`=0, counter 0.
- All outputs are registered; no combinational input-to-output path.
- Goal latency: if `goal_pX` is first sampled high at edge k (it was low at k-1), the new score is visible after edge k. `play_en` falls after the same edge k.
- Serve: the vsync edge that brings the counter to SERVE_FRAMES is sampled at edge m.
  - `serve`=1 for exactly the cycle after edge m.
  - `play_en` rises after edge m.
- `game_over` rises after the same edge as the winning score update.
- Start latency: a `start_in` edge at edge k clears the scores and enters HOLD after edge k.
- Reset asserted mid-match: all registers return to reset values immediately, regardless of `pclk`. After release, the block waits in IDLE for a new `start_in` edge.
- A goal held high across a serve does not rescore; it needs a new rising edge.

## Test plan
- Reset release with all inputs low for 1000 cycles -> stays in IDLE; scores 0/0; `play_en`, `serve` and `game_over` all 0.
- `start_in` edge, then 60 vsync edges (SERVE_FRAMES=60) -> exactly one `serve` pulse after the 60th edge; `play_en`=1; no pulse after the 59th edge.
- In PLAY, raise `goal_p1` for 5 cycles -> `score_p1`=1 after one cycle; `play_en`=0; state HOLD; score still 1 after the next serve.
- Three separate P2 goals, each with a serve in between -> `score_p2` goes 1, 2, 3; `game_over`=1; further goal pulses leave the score at 3; `start_in` edge -> scores 0/0, `game_over`=0, HOLD.
- `goal_p1` and `goal_p2` rise in the same cycle in PLAY -> both scores unchanged; HOLD entered; serve follows after 60 frames.
- Assert `rst` at score 2/1 mid-HOLD, asynchronously to `pclk` -> all outputs 0 immediately, before the next clock edge; `start_in` is needed to resume.
